// File: rtl/bus_sched_pkg.sv
// Shared types and defaults for the supervised bus transaction scheduler.
// No logic here; state encoding and parameter defaults only.
package bus_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, ABORT} sched_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from last+1, wrapping.
// Purely combinational, zero latency; the caller decides when the pick is taken.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    pick       = '0;
    pick_id    = '0;
    pick_valid = 1'b0;
    idx        = '0;
    // k = N_REQ lands back on last itself, so a lone repeat requester still wins.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % N_REQ);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx;
        pick[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_txn_scheduler.sv
// Round-robin bus owner: one transaction at a time, watchdog-aborted after TIMEOUT.
// All outputs registered; grant appears with bus_start one cycle after a request is seen in IDLE.
module bus_txn_scheduler
  import bus_sched_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] err_clear,
  input  logic             bus_complete,
  output logic [N_REQ-1:0] gnt,
  output logic             bus_start,
  output logic             bus_abort,
  output logic [N_REQ-1:0] done,
  output logic             timeout_error,
  output logic [ID_W-1:0]  timeout_id,
  output logic [N_REQ-1:0] err_status,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  sched_state_t     state, state_nxt;
  logic [ID_W-1:0]  id, id_nxt, last, last_nxt, tid_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt, err_nxt, err_set, id_onehot;
  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             start_nxt, abort_nxt, terr_nxt, busy_nxt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req        (req),
    .last       (last),
    .pick       (pick),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign id_onehot = N_REQ'(1) << id;

  always_comb begin
    state_nxt = state;
    id_nxt    = id;
    last_nxt  = last;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    done_nxt  = '0;
    terr_nxt  = 1'b0;
    tid_nxt   = timeout_id;
    err_set   = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (pick_valid) begin
          state_nxt = START;
          id_nxt    = pick_id;
          gnt_nxt   = pick;
          start_nxt = 1'b1;
        end
      end
      START: begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = WAIT;
      end
      WAIT: begin
        // Completion wins over the watchdog on the limit cycle.
        if (bus_complete) begin
          state_nxt = IDLE;
          done_nxt  = id_onehot;
          gnt_nxt   = '0;
          last_nxt  = id;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ABORT;
          abort_nxt = 1'b1;
          terr_nxt  = 1'b1;
          tid_nxt   = id;
          err_set   = id_onehot;
          gnt_nxt   = '0;
          last_nxt  = id;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ABORT: begin
        // Re-assert the set while in ABORT so a clear landing on the abort pulse loses.
        state_nxt = IDLE;
        err_set   = id_onehot;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    err_nxt  = (err_status & ~err_clear) | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      id            <= '0;
      last          <= ID_W'(N_REQ - 1);
      cnt           <= '0;
      gnt           <= '0;
      bus_start     <= 1'b0;
      bus_abort     <= 1'b0;
      done          <= '0;
      timeout_error <= 1'b0;
      timeout_id    <= '0;
      err_status    <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      id            <= id_nxt;
      last          <= last_nxt;
      cnt           <= cnt_nxt;
      gnt           <= gnt_nxt;
      bus_start     <= start_nxt;
      bus_abort     <= abort_nxt;
      done          <= done_nxt;
      timeout_error <= terr_nxt;
      timeout_id    <= tid_nxt;
      err_status    <= err_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bus_txn_scheduler.sv
// Directed bench for bus_txn_scheduler (N_REQ=4, TIMEOUT=5); cycle 0 is the first cycle after reset.
module tb_bus_txn_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] err_clear;
  logic       bus_complete;
  logic [3:0] gnt;
  logic       bus_start;
  logic       bus_abort;
  logic [3:0] done;
  logic       timeout_error;
  logic [1:0] timeout_id;
  logic [3:0] err_status;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  bus_txn_scheduler #(
    .N_REQ   (4),
    .TIMEOUT (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .err_clear     (err_clear),
    .bus_complete  (bus_complete),
    .gnt           (gnt),
    .bus_start     (bus_start),
    .bus_abort     (bus_abort),
    .done          (done),
    .timeout_error (timeout_error),
    .timeout_id    (timeout_id),
    .err_status    (err_status),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    req          = '0;
    err_clear    = '0;
    bus_complete = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // 1: single request, completes at cycle 4
    do_reset();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err",  32'(err_status), 0);
    chk("rst_start", 32'(bus_start), 0);
    chk("rst_tid",  32'(timeout_id), 0);
    req = 4'b0001;
    step();
    chk("t1_start", 32'(bus_start), 1);
    chk("t1_gnt",   32'(gnt), 'h1);
    chk("t1_busy",  32'(busy), 1);
    step();
    chk("t1_start_pulse", 32'(bus_start), 0);
    step(2);
    chk("t1_gnt_c4", 32'(gnt), 'h1);
    bus_complete = 1'b1;
    step();
    bus_complete = 1'b0;
    req = '0;
    chk("t1_done",  32'(done), 'h1);
    chk("t1_gnt_off", 32'(gnt), 0);
    chk("t1_terr",  32'(timeout_error), 0);
    step();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);

    // 2: no completion, abort at cycle 7
    do_reset();
    req = 4'b0010;
    step();
    chk("t2_gnt", 32'(gnt), 'h2);
    step(5);
    chk("t2_no_abort_c6", 32'(bus_abort), 0);
    step();
    req = '0;
    chk("t2_abort", 32'(bus_abort), 1);
    chk("t2_terr",  32'(timeout_error), 1);
    chk("t2_tid",   32'(timeout_id), 1);
    chk("t2_err",   32'(err_status), 'h2);
    chk("t2_gnt_off", 32'(gnt), 0);
    step();
    chk("t2_abort_pulse", 32'(bus_abort), 0);
    chk("t2_tid_hold", 32'(timeout_id), 1);
    chk("t2_err_hold", 32'(err_status), 'h2);

    // 3a: completion exactly at S+5 is a success
    do_reset();
    req = 4'b0001;
    step(6);
    bus_complete = 1'b1;
    step();
    bus_complete = 1'b0;
    req = '0;
    chk("t3a_done",  32'(done), 'h1);
    chk("t3a_abort", 32'(bus_abort), 0);
    chk("t3a_err",   32'(err_status), 0);

    // 3b: completion at S+6 arrives after the abort
    do_reset();
    req = 4'b0001;
    step(7);
    chk("t3b_abort", 32'(bus_abort), 1);
    bus_complete = 1'b1;
    req = '0;
    step();
    bus_complete = 1'b0;
    chk("t3b_no_done", 32'(done), 0);
    chk("t3b_idle",    32'(busy), 0);
    chk("t3b_err",     32'(err_status), 'h1);

    // 4: round-robin with all requesting, completion 2 cycles after start
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_start%0d", i), 32'(bus_start), 1);
      chk($sformatf("t4_gnt%0d", i),   32'(gnt), 32'(order[i]));
      step(2);
      bus_complete = 1'b1;
      step();
      bus_complete = 1'b0;
      chk($sformatf("t4_done%0d", i), 32'(done), 32'(order[i]));
      step();
    end
    req = '0;

    // 5a: reset during WAIT, no abort, pointer back to requester 0
    do_reset();
    req = 4'b0100;
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5a_gnt",   32'(gnt), 0);
    chk("t5a_busy",  32'(busy), 0);
    chk("t5a_abort", 32'(bus_abort), 0);
    chk("t5a_start", 32'(bus_start), 0);
    req = 4'b1001;
    step();
    chk("t5a_regnt", 32'(gnt), 'h1);
    req = '0;
    step();
    bus_complete = 1'b1;
    step();
    bus_complete = 1'b0;
    chk("t5a_done", 32'(done), 'h1);

    // 5b: err_clear collides with the abort of requester 2
    do_reset();
    req = 4'b0100;
    step(6);
    err_clear = 4'b0100;
    step();
    chk("t5b_abort", 32'(bus_abort), 1);
    chk("t5b_err",   32'(err_status), 'h4);
    step();
    err_clear = '0;
    req = '0;
    chk("t5b_set_wins", 32'(err_status), 'h4);
    err_clear = 4'b0100;
    step();
    err_clear = '0;
    chk("t5b_cleared", 32'(err_status), 0);

    // 6: bus_complete in IDLE and START is ignored
    do_reset();
    bus_complete = 1'b1;
    step();
    bus_complete = 1'b0;
    chk("t6_idle_done", 32'(done), 0);
    chk("t6_idle_busy", 32'(busy), 0);
    req = 4'b1000;
    step();
    chk("t6_gnt", 32'(gnt), 'h8);
    bus_complete = 1'b1;
    step();
    bus_complete = 1'b0;
    chk("t6_start_done", 32'(done), 0);
    chk("t6_busy", 32'(busy), 1);
    step(4);
    chk("t6_no_abort", 32'(bus_abort), 0);
    step();
    req = '0;
    chk("t6_abort", 32'(bus_abort), 1);
    chk("t6_tid",   32'(timeout_id), 3);
    chk("t6_err",   32'(err_status), 'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
